rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between N_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Uses a round-robin grant with a valid/ready handshake per requester.
- Registers the winning write one cycle before it is driven onto the register file write port.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
- N_REQ, 2, number of writeback requesters; legal range 2..8.
- PTR_W, $clog2(N_REQ), width of the round-robin pointer; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  freeze; no new grants while high.
- req_valid  in  N_REQ  requester i has a write pending.
- req_ready  out  N_REQ  requester i granted this cycle; one-hot or zero.
- req_addr  in  N_REQ x reg_addr_t  destination register per requester.
- req_data  in  N_REQ x word_t  write data per requester.
- rf_write_en  out  1  register file write enable.
- rf_rd_addr  out  reg_addr_t  register file destination address.
- rf_rd_data  out  word_t  register file write data.
- wb_busy  out  1  output stage holds a valid entry.

Behaviour:
- Reset (rst low, asynchronous): stage_valid=0, stage_addr=0, stage_data=0, ptr=0.
  - All outputs are 0 during reset: rf_write_en, rf_rd_addr, rf_rd_data, wb_busy, req_ready.
  - Reset mid-operation discards the staged write; no register file write occurs for it.
- Grant (combinational):
  - With hold=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[i]=1 only for the granted i.
  - hold=1 or no valid requester: req_ready all 0.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - The requester holds valid, addr and data stable until ready.
  - The arbiter never withdraws ready within a cycle.
- Stage register:
  - On a transfer, stage_valid<=1, stage_addr<=req_addr[i], stage_data<=req_data[i].
  - With no transfer, stage_valid<=0.
  - The register file always accepts, so the stage drains every cycle and there are no stall bubbles.
  - Throughput is one write per cycle; latency is one cycle from handshake to rf_write_en.
- Pointer: after granting i, ptr<=(i+1) mod N_REQ. No grant leaves ptr unchanged.
- Outputs: rf_write_en = stage_valid & (stage_addr != 0). rf_rd_addr = stage_addr, rf_rd_data = stage_data, wb_busy = stage_valid.
- x0 writes are accepted (ready asserted, stage loaded) but never raise rf_write_en.
- hold has no effect on an already-staged entry; that entry still writes the next cycle.
- Two requesters targeting the same register in consecutive cycles: both writes are issued in grant order, and the later one wins.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- With the macro defined, the block adds these ports:
  - rs1_addr, rs2_addr  in  reg_addr_t.
  - rf_rs1_data, rf_rs2_data  in  word_t  raw register file reads.
  - rs1_fwd, rs2_fwd  out  word_t.
- rsX_fwd = stage_data when stage_valid & stage_addr==rsX_addr & rsX_addr!=0; otherwise rf_rsX_data.
- Forwarding is combinational with no added latency, and covers a read in the same cycle the staged write commits.
- Without the macro, those ports are absent and the readers use the register file outputs directly.

Decomposition:
- types.sv provides reg_addr_t and word_t, which are reused unchanged.
- Add to the shared package: constant REG_ZERO = 5'd0 and the macro default documentation.
- One sub-module, rr_arbiter: parameterised N, taking req vector, ptr and enable, producing the one-hot grant.
  - It is purely combinational and reusable for future bus arbiters.
- The pointer and stage registers stay in rf_wb_arbiter.

Test Plan:
- Reset: rst low with req_valid=2'b11 → req_ready=0, rf_write_en=0, wb_busy=0. Release rst → first grant goes to req 0 (ptr=0).
- Fairness: both valid for 4 cycles, req0 addr=5 data=0xA, req1 addr=6 data=0xB → grants 0,1,0,1; rf_write_en each cycle from cycle 2 with addr 5,6,5,6.
- x0 drop: req0 addr=0 data=0xDEAD → req_ready[0]=1, wb_busy=1 next cycle, rf_write_en=0.
- Hold: hold=1 with req1 valid for 3 cycles → req_ready=0 throughout. Drop hold → req1 granted; write appears 1 cycle later.
- Async reset mid-write: handshake at cycle t, rst asserted low mid-cycle t+1 → rf_write_en falls immediately; register file at that address keeps its old value.
- Bypass (RF_WB_BYPASS_EN): stage holds addr=7 data=0x1234, rs1_addr=7, rf_rs1_data=0 → rs1_fwd=0x1234. rs2_addr=0 → rs2_fwd=rf_rs2_data.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// RF_WB_BYPASS_EN: undefined by default; define it to add the stage-to-reader forwarding ports.
// Helper fwd_pick implements the single-operand forwarding select.
package rf_wb_arbiter_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // x0 is hardwired, so a staged x0 write must never shadow a raw read.
    function automatic word_t fwd_pick(
        input logic      stage_vld,
        input reg_addr_t stage_addr,
        input word_t     stage_dat,
        input reg_addr_t rd_addr,
        input word_t     raw_dat
    );
        if (stage_vld && (stage_addr == rd_addr) && (rd_addr != REG_ZERO)) begin
            return stage_dat;
        end
        return raw_dat;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin one-hot grant over N requesters, search starting at ptr.
// Latency: purely combinational. Backpressure: en=0 forces an all-zero grant.
// Reusable for other arbiters; the caller owns the pointer register.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N);

    logic [PTR_W:0] w_idx;
    logic           w_found;

    // Walk ptr, ptr+1, ... wrapping at N; the first set request wins.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_idx >= N_EXT) begin
                w_idx = w_idx - N_EXT;
            end
            if (en && !w_found && req[w_idx[PTR_W-1:0]]) begin
                grant[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among N_REQ requesters (round-robin); optional RF_WB_BYPASS_EN forwarding.
// Latency: one cycle from handshake to rf_write_en; one write per cycle sustained.
// Backpressure: req_ready withheld while hold=1 or in reset; the register file always accepts.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic      [N_REQ-1:0] req_valid,
    output logic      [N_REQ-1:0] req_ready,
    input  reg_addr_t [N_REQ-1:0] req_addr,
    input  word_t     [N_REQ-1:0] req_data,
    output logic                  rf_write_en,
    output reg_addr_t             rf_rd_addr,
    output word_t                 rf_rd_data,
    output logic                  wb_busy
`ifdef RF_WB_BYPASS_EN
    ,
    input  reg_addr_t             rs1_addr,
    input  reg_addr_t             rs2_addr,
    input  word_t                 rf_rs1_data,
    input  word_t                 rf_rs2_data,
    output word_t                 rs1_fwd,
    output word_t                 rs2_fwd
`endif
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic             r_stage_valid;
    reg_addr_t        r_stage_addr;
    word_t            r_stage_data;
    logic [PTR_W-1:0] r_ptr;

    logic [N_REQ-1:0] w_grant;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_xfer;
    logic             w_arb_en;

    // Gating with rst keeps req_ready low for the whole reset window.
    assign w_arb_en = rst & ~hold;

    rr_arbiter #(
        .N     (N_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_xfer    = |w_grant;
    assign w_ptr_nxt = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + PTR_W'(1);
    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage_valid <= 1'b0;
            r_stage_addr  <= REG_ZERO;
            r_stage_data  <= '0;
            r_ptr         <= '0;
        end else begin
            r_stage_valid <= w_xfer;
            if (w_xfer) begin
                r_stage_addr <= req_addr[w_gnt_idx];
                r_stage_data <= req_data[w_gnt_idx];
                r_ptr        <= w_ptr_nxt;
            end
        end
    end

    // x0 writes occupy the stage but are never presented to the register file.
    assign rf_write_en = r_stage_valid & (r_stage_addr != REG_ZERO);
    assign rf_rd_addr  = r_stage_addr;
    assign rf_rd_data  = r_stage_data;
    assign wb_busy     = r_stage_valid;

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd = fwd_pick(r_stage_valid, r_stage_addr, r_stage_data, rs1_addr, rf_rs1_data);
    assign rs2_fwd = fwd_pick(r_stage_valid, r_stage_addr, r_stage_data, rs2_addr, rf_rs2_data);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter against a queue-free behavioural model.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hold;
    logic      [N-1:0]    req_valid;
    logic      [N-1:0]    req_ready;
    reg_addr_t [N-1:0]    req_addr;
    word_t     [N-1:0]    req_data;
    logic                 rf_write_en;
    reg_addr_t            rf_rd_addr;
    word_t                rf_rd_data;
    logic                 wb_busy;
`ifdef RF_WB_BYPASS_EN
    reg_addr_t            rs1_addr, rs2_addr;
    word_t                rf_rs1_data, rf_rs2_data, rs1_fwd, rs2_fwd;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    int    m_ptr;
    bit    m_valid;
    int    m_addr;
    word_t m_data;
    word_t m_mem  [32];
    word_t rf_mem [32];

    rf_wb_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_write_en (rf_write_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .wb_busy     (wb_busy)
`ifdef RF_WB_BYPASS_EN
        ,
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rs1_fwd     (rs1_fwd),
        .rs2_fwd     (rs2_fwd)
`endif
    );

    always #5 clk = ~clk;

    // Register file image built only from what the DUT actually writes.
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_rd_addr] <= rf_rd_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!rst || hold) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Inputs are already set (just after negedge); check, advance one clock, update model.
    task automatic cycle(output int g);
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rf_write_en", 32'(rf_write_en), 32'(m_valid && m_addr != 0));
        check("wb_busy", 32'(wb_busy), 32'(m_valid));
        if (m_valid) begin
            check("rf_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
            check("rf_rd_data", rf_rd_data, m_data);
        end
        @(posedge clk);
        if (m_valid && m_addr != 0) m_mem[m_addr] = m_data;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_addr  = int'(req_addr[g]);
            m_data  = req_data[g];
            m_ptr   = (g + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int g;
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            rf_mem[i] = '0;
        end
        rst = 1'b0; hold = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        m_ptr = 0; m_valid = 1'b0; m_addr = 0; m_data = '0;
`ifdef RF_WB_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
`endif

        // Reset with both requesters pending.
        req_valid = 2'b11;
        req_addr[0] = 5'd5; req_data[0] = 32'hA;
        req_addr[1] = 5'd6; req_data[1] = 32'hB;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wr_en", 32'(rf_write_en), 32'd0);
        check("rst_busy", 32'(wb_busy), 32'd0);
        check("rst_addr", 32'(rf_rd_addr), 32'd0);
        check("rst_data", rf_rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fairness: grants alternate starting at requester 0.
        #1;
        check("first_grant", 32'(req_ready), 32'd1);
        repeat (4) cycle(g);
        req_valid = '0;
        cycle(g);
        cycle(g);

        // x0 write is accepted but never enables the write port.
        req_valid = 2'b01; req_addr[0] = REG_ZERO; req_data[0] = 32'hDEAD;
        cycle(g);
        req_valid = '0;
        cycle(g);

        // Hold blocks grants; release grants requester 1.
        hold = 1'b1; req_valid = 2'b10; req_addr[1] = 5'd3; req_data[1] = 32'h3333;
        repeat (3) cycle(g);
        hold = 1'b0;
        cycle(g);
        req_valid = '0;
        cycle(g);
        cycle(g);

        // Same destination from both requesters back to back: later grant wins.
        req_valid = 2'b11;
        req_addr[0] = 5'd10; req_data[0] = 32'h1111;
        req_addr[1] = 5'd10; req_data[1] = 32'h2222;
        repeat (2) cycle(g);
        req_valid = '0;
        repeat (2) cycle(g);
        check("collide_r10", rf_mem[10], m_mem[10]);

`ifdef RF_WB_BYPASS_EN
        req_valid = 2'b01; req_addr[0] = 5'd7; req_data[0] = 32'h1234;
        cycle(g);
        req_valid = '0;
        rs1_addr = 5'd7; rf_rs1_data = 32'h0;
        rs2_addr = 5'd0; rf_rs2_data = 32'hABCD;
        #1;
        check("rs1_fwd", rs1_fwd, 32'h1234);
        check("rs2_fwd_x0", rs2_fwd, 32'hABCD);
        rs1_addr = 5'd8; rf_rs1_data = 32'h5;
        #1;
        check("rs1_nofwd", rs1_fwd, 32'h5);
        @(negedge clk);
`endif

        // Establish an old value in x9, then reset while the overwrite is staged.
        req_valid = 2'b01; req_addr[0] = 5'd9; req_data[0] = 32'h55;
        cycle(g);
        req_valid = '0;
        cycle(g);
        req_valid = 2'b01; req_data[0] = 32'h99;
        cycle(g);
        req_valid = '0;
        #1;
        check("pre_rst_wr_en", 32'(rf_write_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(rf_write_en), 32'd0);
        check("mid_rst_busy", 32'(wb_busy), 32'd0);
        check("mid_rst_addr", 32'(rf_rd_addr), 32'd0);
        m_valid = 1'b0; m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_keeps_r9", rf_mem[9], 32'h55);
        @(negedge clk);

        // Random traffic; requesters keep addr/data stable until granted.
        g = -1;
        repeat (400) begin
            if (g >= 0) req_valid[g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i]  = 5'($urandom_range(0, 12));
                    req_data[i]  = $urandom;
                end
            end
            hold = ($urandom_range(0, 7) == 0);
            cycle(g);
        end
        if (g >= 0) req_valid[g] = 1'b0;
        req_valid = '0; hold = 1'b0;
        repeat (2) cycle(g);

        for (int i = 0; i < 32; i++) begin
            check($sformatf("mem_r%0d", i), rf_mem[i], m_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
